smg_scan_control: RTL and testbench
===================================

# smg_scan_control

Multiplexed scan controller for an N-digit common-anode seven-segment display. It holds a per-digit nibble image, steps through the digits on a programmable slot period, and feeds one nibble at a time to the registered `smg_encode_module` through `Number_Data`. It drives the active-low digit enables (`Scan_Sig`) with dead time, so the encoder's one-cycle output latency never produces ghosting. Host writes are double-buffered and only take effect at a frame boundary, so a digit image never tears mid-frame.

## Interface

Parameters:
- `NUM_DIGITS`, default 6: number of digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must satisfy `SCAN_DIV > DEAD`.
- `DEAD`, default 2: leading cycles of each slot during which all digits are off. Must be ≥ 1.

Ports (clock and reset first):
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `En`  in  1  scan enable; low forces the display dark and parks the scan at digit 0.
- `Load`  in  1  single-cycle write strobe for `Data_In` and `Blank_In`.
- `Data_In`  in  4×NUM_DIGITS  digit nibbles; bits [4i+3:4i] belong to digit i.
- `Blank_In`  in  NUM_DIGITS  per-digit blank; 1 means the digit stays off.
- `Number_Data`  out  4  nibble for the current digit, connected to the encoder's `Number_Data`.
- `Scan_Sig`  out  NUM_DIGITS  digit enables, active-low, registered.
- `Frame_Start`  out  1  one-cycle pulse on the first cycle of each frame.

## Operation

Counters:
- `cnt` runs 0..SCAN_DIV-1.
- `idx` runs 0..NUM_DIGITS-1.
- `cnt` increments every enabled cycle. When `cnt` wraps to 0, `idx` advances; `idx` wraps from NUM_DIGITS-1 to 0.

Buffers:
- The pending buffer (data plus blank) captures `Data_In` and `Blank_In` on any cycle with `Load`=1.
- The active buffer copies the pending buffer only at the frame-wrap edge, where (idx,cnt) goes from (NUM_DIGITS-1, SCAN_DIV-1) to (0,0). The copied value is the pending buffer as it stood before that edge.
- If `Load` falls on the same edge as the frame wrap, the new data lands in pending and appears one frame later.

Slot phases for digit i:
- DEAD phase, cnt < DEAD: `Scan_Sig` is all ones.
- ON phase: `Scan_Sig` = ~(1<<i). If active `Blank[i]`=1, `Scan_Sig` stays all ones for the whole slot.

Nibble output:
- `Number_Data` is registered. It loads the active nibble for the new idx on the same edge at which `cnt` becomes 0.
- It is updated even for blanked digits.
- Because DEAD ≥ 1, the encoder output is valid before any enable asserts.

Disable (`En`=0):
- The next edge forces cnt=0, idx=0 and `Scan_Sig` all ones. `Number_Data` holds. No buffer transfer occurs. `Load` still writes the pending buffer.
- When `En` returns to 1, slot 0 begins with its DEAD phase. `Number_Data` loads active nibble 0 on the first enabled edge.

Reset (RST=1, overrides everything):
- cnt=0, idx=0.
- `Scan_Sig` all ones, `Number_Data`=4'h0, `Frame_Start`=0.
- Pending and active data are 0. Pending and active blank are all ones, so the display is dark until a load has propagated through one frame wrap.
- Reset asserted mid-frame gives the same values on the next edge.

## Timing

- `Frame_Start` is a registered pulse, high for exactly the cycle following the frame-wrap edge, i.e. the first cycle of slot 0. It does not pulse on reset release or when `En` rises.
- Load-to-display latency: from the `Load` cycle to the next frame-wrap edge. This is at most NUM_DIGITS×SCAN_DIV cycles, plus DEAD cycles before the enable asserts.
- Slot timing: each digit's enable is low for SCAN_DIV−DEAD consecutive cycles. The full frame is NUM_DIGITS×SCAN_DIV cycles.
- Simultaneous `Load` and `RST`: reset wins and pending keeps its reset value.

## Test plan

Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, DEAD=2.

- **Reset:** hold RST=1 for 3 cycles -> `Scan_Sig`=4'b1111, `Number_Data`=0, `Frame_Start`=0. With En=1 and no Load, the display stays 4'b1111 for 3 full frames.
- **Basic scan:** `Load` with 16'h4321 and `Blank_In`=0; wait for `Frame_Start` -> slot 0 shows `Number_Data`=1, `Scan_Sig`=1111 for 2 cycles then 1110 for 6. Slots 1, 2, 3 show 2/1101, 3/1011, 4/0111. `Frame_Start` recurs every 32 cycles.
- **Double buffering:** `Load` 16'hABCD in the middle of slot 2 -> the current frame still shows the old nibbles; the new ones appear after the next `Frame_Start`. `Load` on the frame-wrap edge itself -> the new data appears one frame later.
- **Blanking:** `Blank_In`=4'b1000 -> during the slot-3 window `Scan_Sig` stays 4'b1111 for all 8 cycles while `Number_Data`=4'hA still updates. The other digits are unaffected.
- **Disable:** drop `En` in slot 2 cycle 4 -> next cycle `Scan_Sig`=1111, idx=0. Raise `En` -> 2 dead cycles, then `Scan_Sig`=1110 with nibble 0. No `Frame_Start` pulse.
- **Reset mid-operation:** assert RST during the slot-1 ON phase -> next cycle `Scan_Sig`=1111 and `Number_Data`=0. The display stays dark until a new Load completes a frame wrap.

Source files
------------

// File: rtl/smg_scan_control.sv
// smg_scan_control
//
// Multiplexed scan controller for an N-digit common-anode seven-segment
// display. It keeps a per-digit nibble image, walks through the digits one
// slot at a time and hands the current digit's nibble to the registered
// segment encoder. The digit enables are held off for the first DEAD cycles
// of every slot. This hides the encoder's one-cycle latency, so a digit never
// lights with the previous digit's segments.
//
// Host writes go into a pending buffer. The pending buffer is copied to the
// active buffer only at the frame wrap, so a frame never shows a half-updated
// image.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   En           scan enable; low darkens the display and parks at digit 0
//   Load         single-cycle write strobe for Data_In / Blank_In
//   Data_In      digit nibbles, bits [4i+3:4i] belong to digit i
//   Blank_In     per-digit blank, 1 keeps the digit off
//   Number_Data  registered nibble for the current digit (to the encoder)
//   Scan_Sig     registered active-low digit enables
//   Frame_Start  one-cycle pulse on the first cycle of each frame
module smg_scan_control #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD       = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    En,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Data_In,
  input  logic [NUM_DIGITS-1:0]   Blank_In,
  output logic [3:0]              Number_Data,
  output logic [NUM_DIGITS-1:0]   Scan_Sig,
  output logic                    Frame_Start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      DEAD_CNT = CNT_W'(DEAD);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = '1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pendData_q, pendData_d;
  logic [NUM_DIGITS-1:0]   pendBlank_q, pendBlank_d;
  logic [4*NUM_DIGITS-1:0] actData_q, actData_d;
  logic [NUM_DIGITS-1:0]   actBlank_q, actBlank_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   scan_q, scan_d;
  logic                    frameStart_q, frameStart_d;
  logic                    frameWrap;

  // Next-state logic. Every registered output is computed from the
  // post-edge counter and buffer values. Each output register therefore
  // describes the same slot position as the counters in the cycle it is
  // visible.
  always_comb begin
    frameWrap   = En && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pendData_d  = pendData_q;
    pendBlank_d = pendBlank_q;
    actData_d   = actData_q;
    actBlank_d  = actBlank_q;
    nibble_d    = nibble_q;
    scan_d      = ALL_OFF;

    // The pending buffer accepts writes even while the scan is disabled.
    if (Load) begin
      pendData_d  = Data_In;
      pendBlank_d = Blank_In;
    end

    if (!En) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The active buffer takes the pending value as it stood before the
    // wrap edge. A Load on the wrap edge itself therefore waits a full frame.
    if (frameWrap) begin
      actData_d  = pendData_q;
      actBlank_d = pendBlank_q;
    end

    // The nibble is loaded when a slot starts. It is also reloaded on the
    // first enabled edge out of the parked state, which is the only time
    // cnt leaves 0 without having just wrapped. In steady running that
    // reload rewrites the same value.
    if (En && ((cnt_d == '0) || (cnt_q == '0))) begin
      nibble_d = actData_d[int'(idx_d)*4 +: 4];
    end

    if (En && (cnt_d >= DEAD_CNT) && !actBlank_d[idx_d]) begin
      scan_d = ~(NUM_DIGITS'(1) << idx_d);
    end

    frameStart_d = frameWrap;
  end

  // State registers. Reset leaves both blank masks all ones, so the
  // display stays dark until a host write has passed through a frame wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pendData_q   <= '0;
      pendBlank_q  <= '1;
      actData_q    <= '0;
      actBlank_q   <= '1;
      nibble_q     <= 4'h0;
      scan_q       <= ALL_OFF;
      frameStart_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pendData_q   <= pendData_d;
      pendBlank_q  <= pendBlank_d;
      actData_q    <= actData_d;
      actBlank_q   <= actBlank_d;
      nibble_q     <= nibble_d;
      scan_q       <= scan_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign Number_Data = nibble_q;
  assign Scan_Sig    = scan_q;
  assign Frame_Start = frameStart_q;

endmodule

// File: tb/tb_smg_scan_control.sv
// tb_smg_scan_control
//
// Directed bench for smg_scan_control with 4 digits, 8-cycle slots and
// 2 dead cycles, so a frame is 32 cycles. Position "c" below counts cycles
// from the first cycle of a frame (slot = c/8, cycle in slot = c%8).
// Expected values come from small model functions of (data, blank, c).
module tb_smg_scan_control;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 8;
  localparam int DEAD       = 2;
  localparam int FRAME      = NUM_DIGITS * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RST;
  logic        En;
  logic        Load;
  logic [15:0] Data_In;
  logic [3:0]  Blank_In;
  logic [3:0]  Number_Data;
  logic [3:0]  Scan_Sig;
  logic        Frame_Start;

  int checks = 0;
  int passed = 0;

  smg_scan_control #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .DEAD      (DEAD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .En         (En),
    .Load       (Load),
    .Data_In    (Data_In),
    .Blank_In   (Blank_In),
    .Number_Data(Number_Data),
    .Scan_Sig   (Scan_Sig),
    .Frame_Start(Frame_Start)
  );

  // Free-running clock with a 10 ns period
  always #5 CLK = ~CLK;

  // Safety net in case the bench itself loses its way
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected nibble at frame position c for a given image
  function automatic logic [3:0] expNibble(input logic [15:0] data, input int c);
    logic [15:0] d;
    d = data;
    return d[4*(c / SCAN_DIV) +: 4];
  endfunction

  // Expected active-low enables at frame position c
  function automatic logic [3:0] expScan(input logic [3:0] blank, input int c);
    int slot;
    int k;
    slot = c / SCAN_DIV;
    k    = c % SCAN_DIV;
    if (k < DEAD || blank[slot]) return 4'hF;
    return ~(4'(1) << slot);
  endfunction

  // Step until Frame_Start is seen or the limit runs out
  task automatic waitFrameStart(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (Frame_Start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; En = 1'b0; Load = 1'b0; Data_In = '0; Blank_In = '0;
    repeat (3) step();
    checks++;
    if (Scan_Sig !== 4'hF) $display("[TB] FAIL reset_scan: got %b expected 1111", Scan_Sig);
    else passed++;
    checks++;
    if (Number_Data !== 4'h0) $display("[TB] FAIL reset_nibble: got %h expected 0", Number_Data);
    else passed++;
    checks++;
    if (Frame_Start !== 1'b0) $display("[TB] FAIL reset_fs: got %b expected 0", Frame_Start);
    else passed++;
    RST = 1'b0; En = 1'b1;
    for (int c = 0; c < 3*FRAME; c++) begin
      checks++;
      if (Scan_Sig !== 4'hF) $display("[TB] FAIL reset_dark c=%0d: got %b expected 1111", c, Scan_Sig);
      else passed++;
      step();
    end
  endtask

  task automatic test_basic_scan();
    bit found;
    waitFrameStart(2*FRAME, found);
    checks++;
    if (!found) $display("[TB] FAIL basic_sync: got no Frame_Start expected a pulse");
    else passed++;
    repeat (3) step();
    Load = 1'b1; Data_In = 16'h4321; Blank_In = 4'b0000;
    step();
    Load = 1'b0;
    waitFrameStart(FRAME + 4, found);
    checks++;
    if (!found) $display("[TB] FAIL basic_wait: got no Frame_Start expected a pulse");
    else passed++;
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'h4321, c) || Scan_Sig !== expScan(4'b0000, c) ||
          Frame_Start !== (c == 0))
        $display("[TB] FAIL basic c=%0d: got nib=%h scan=%b fs=%b expected nib=%h scan=%b fs=%b",
                 c, Number_Data, Scan_Sig, Frame_Start,
                 expNibble(16'h4321, c), expScan(4'b0000, c), (c == 0));
      else passed++;
      step();
    end
    checks++;
    if (Frame_Start !== 1'b1) $display("[TB] FAIL basic_period: got fs=%b expected 1", Frame_Start);
    else passed++;
  endtask

  task automatic test_double_buffer();
    // Mid-frame load: the current frame keeps the old image
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'h4321, c) || Scan_Sig !== expScan(4'b0000, c) ||
          Frame_Start !== (c == 0))
        $display("[TB] FAIL dbuf_old c=%0d: got nib=%h scan=%b fs=%b expected nib=%h scan=%b fs=%b",
                 c, Number_Data, Scan_Sig, Frame_Start,
                 expNibble(16'h4321, c), expScan(4'b0000, c), (c == 0));
      else passed++;
      if (c == 20) begin
        Load = 1'b1; Data_In = 16'hABCD; Blank_In = 4'b0000;
      end else begin
        Load = 1'b0;
      end
      step();
    end
    // New image after the wrap; load again exactly on the wrap edge
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hABCD, c) || Scan_Sig !== expScan(4'b0000, c) ||
          Frame_Start !== (c == 0))
        $display("[TB] FAIL dbuf_new c=%0d: got nib=%h scan=%b fs=%b expected nib=%h scan=%b fs=%b",
                 c, Number_Data, Scan_Sig, Frame_Start,
                 expNibble(16'hABCD, c), expScan(4'b0000, c), (c == 0));
      else passed++;
      if (c == FRAME - 1) begin
        Load = 1'b1; Data_In = 16'h5678; Blank_In = 4'b0000;
      end else begin
        Load = 1'b0;
      end
      step();
    end
    Load = 1'b0;
    // A load on the wrap edge is one frame late
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hABCD, c) || Scan_Sig !== expScan(4'b0000, c))
        $display("[TB] FAIL dbuf_wrapload c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'hABCD, c), expScan(4'b0000, c));
      else passed++;
      step();
    end
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'h5678, c) || Scan_Sig !== expScan(4'b0000, c))
        $display("[TB] FAIL dbuf_late c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'h5678, c), expScan(4'b0000, c));
      else passed++;
      step();
    end
  endtask

  task automatic test_blanking();
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'h5678, c) || Scan_Sig !== expScan(4'b0000, c))
        $display("[TB] FAIL blank_pre c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'h5678, c), expScan(4'b0000, c));
      else passed++;
      if (c == 5) begin
        Load = 1'b1; Data_In = 16'hA987; Blank_In = 4'b1000;
      end else begin
        Load = 1'b0;
      end
      step();
    end
    Load = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hA987, c) || Scan_Sig !== expScan(4'b1000, c) ||
          Frame_Start !== (c == 0))
        $display("[TB] FAIL blank c=%0d: got nib=%h scan=%b fs=%b expected nib=%h scan=%b fs=%b",
                 c, Number_Data, Scan_Sig, Frame_Start,
                 expNibble(16'hA987, c), expScan(4'b1000, c), (c == 0));
      else passed++;
      step();
    end
  endtask

  task automatic test_disable();
    for (int c = 0; c <= 20; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hA987, c) || Scan_Sig !== expScan(4'b1000, c))
        $display("[TB] FAIL dis_pre c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'hA987, c), expScan(4'b1000, c));
      else passed++;
      if (c == 20) En = 1'b0;
      step();
    end
    // Disabled: dark, nibble of digit 2 held, no pulse
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (Scan_Sig !== 4'hF || Number_Data !== 4'h9 || Frame_Start !== 1'b0)
        $display("[TB] FAIL dis_hold i=%0d: got nib=%h scan=%b fs=%b expected nib=9 scan=1111 fs=0",
                 i, Number_Data, Scan_Sig, Frame_Start);
      else passed++;
      step();
    end
    En = 1'b1;
    checks++;
    if (Scan_Sig !== 4'hF || Number_Data !== 4'h9 || Frame_Start !== 1'b0)
      $display("[TB] FAIL dis_rise: got nib=%h scan=%b fs=%b expected nib=9 scan=1111 fs=0",
               Number_Data, Scan_Sig, Frame_Start);
    else passed++;
    step();
    // Re-enabled slot 0 restarts with its dead phase and no Frame_Start
    for (int c = 1; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hA987, c) || Scan_Sig !== expScan(4'b1000, c) ||
          Frame_Start !== 1'b0)
        $display("[TB] FAIL dis_resume c=%0d: got nib=%h scan=%b fs=%b expected nib=%h scan=%b fs=0",
                 c, Number_Data, Scan_Sig, Frame_Start,
                 expNibble(16'hA987, c), expScan(4'b1000, c));
      else passed++;
      step();
    end
    checks++;
    if (Frame_Start !== 1'b1) $display("[TB] FAIL dis_wrap: got fs=%b expected 1", Frame_Start);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int c = 0; c <= 11; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'hA987, c) || Scan_Sig !== expScan(4'b1000, c))
        $display("[TB] FAIL rmid_pre c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'hA987, c), expScan(4'b1000, c));
      else passed++;
      if (c == 11) begin
        // Load coincides with reset; reset must win
        RST = 1'b1; Load = 1'b1; Data_In = 16'hFFFF; Blank_In = 4'b0000;
      end
      step();
    end
    checks++;
    if (Scan_Sig !== 4'hF || Number_Data !== 4'h0 || Frame_Start !== 1'b0)
      $display("[TB] FAIL rmid: got nib=%h scan=%b fs=%b expected nib=0 scan=1111 fs=0",
               Number_Data, Scan_Sig, Frame_Start);
    else passed++;
    RST = 1'b0; Load = 1'b0;
    for (int c = 0; c < 2*FRAME; c++) begin
      checks++;
      if (Scan_Sig !== 4'hF) $display("[TB] FAIL rmid_dark c=%0d: got %b expected 1111", c, Scan_Sig);
      else passed++;
      step();
    end
    Load = 1'b1; Data_In = 16'h1234; Blank_In = 4'b0000;
    step();
    Load = 1'b0;
    waitFrameStart(FRAME + 2, found);
    checks++;
    if (!found) $display("[TB] FAIL rmid_wait: got no Frame_Start expected a pulse");
    else passed++;
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (Number_Data !== expNibble(16'h1234, c) || Scan_Sig !== expScan(4'b0000, c))
        $display("[TB] FAIL rmid_reload c=%0d: got nib=%h scan=%b expected nib=%h scan=%b",
                 c, Number_Data, Scan_Sig, expNibble(16'h1234, c), expScan(4'b0000, c));
      else passed++;
      step();
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_blanking();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
